// File: rtl/flit_replay_timeout_ctrl.sv
// Flit-mode TX replay scheduler: detects replay timeout or NAK, requests replays from the retry
// buffer, tracks REPLAY_NUM and escalates to link retrain when REPLAY_NUM rolls over.
module flit_replay_timeout_ctrl #(
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned RNUM_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  replay_timeout_flit_count,
  input  logic [CNT_W-1:0]  cfg_timeout_limit,
  input  logic              ack_progress,
  input  logic              nak,
  input  logic              tx_retry_buffer_not_empty,
  input  logic              replay_done,
  input  logic              retrain_done,
  output logic              replay_req,
  output logic              retrain_req,
  output logic              timer_hold,
  output logic [RNUM_W-1:0] replay_num,
  output logic              timeout_event,
  output logic              replay_cause_nak
);

  typedef enum logic [1:0] {
    StIdle,
    StReplay,
    StRetrain
  } state_e;

  localparam logic [RNUM_W-1:0] RNumMax = {RNUM_W{1'b1}};

  state_e            state_q, state_d;
  logic              replay_req_q, replay_req_d;
  logic              retrain_req_q, retrain_req_d;
  logic              timer_hold_q, timer_hold_d;
  logic [RNUM_W-1:0] replay_num_q, replay_num_d;
  logic              timeout_event_q, timeout_event_d;
  logic              cause_nak_q, cause_nak_d;

  logic              to_hit;
  logic              trig;
  logic [RNUM_W-1:0] eff_num;

  assign to_hit  = (cfg_timeout_limit != '0) &&
                   (replay_timeout_flit_count >= cfg_timeout_limit) &&
                   tx_retry_buffer_not_empty;
  assign trig    = to_hit || (nak && tx_retry_buffer_not_empty);
  // A same-cycle Ack restarts the replay sequence before this trigger counts.
  assign eff_num = ack_progress ? '0 : replay_num_q;

  always_comb begin
    state_d         = state_q;
    replay_req_d    = replay_req_q;
    retrain_req_d   = retrain_req_q;
    timer_hold_d    = timer_hold_q;
    replay_num_d    = replay_num_q;
    timeout_event_d = 1'b0;
    cause_nak_d     = cause_nak_q;

    unique case (state_q)
      StIdle: begin
        if (ack_progress && !nak) begin
          replay_num_d = '0;
        end else if (trig) begin
          if (eff_num == RNumMax) begin
            replay_num_d  = '0;
            retrain_req_d = 1'b1;
            state_d       = StRetrain;
          end else begin
            replay_num_d = eff_num + RNUM_W'(1);
            replay_req_d = 1'b1;
            state_d      = StReplay;
          end
          timer_hold_d    = 1'b1;
          cause_nak_d     = nak;
          timeout_event_d = !nak;
        end
      end
      StReplay: begin
        if (ack_progress) begin
          replay_num_d = '0;
        end
        if (replay_done) begin
          replay_req_d = 1'b0;
          timer_hold_d = 1'b0;
          state_d      = StIdle;
        end
      end
      StRetrain: begin
        // Replay after retrain is not counted and is not a timeout event.
        if (retrain_done) begin
          retrain_req_d = 1'b0;
          replay_req_d  = 1'b1;
          state_d       = StReplay;
        end
      end
      default: begin
        state_d       = StIdle;
        replay_req_d  = 1'b0;
        retrain_req_d = 1'b0;
        timer_hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      replay_req_q    <= 1'b0;
      retrain_req_q   <= 1'b0;
      timer_hold_q    <= 1'b0;
      replay_num_q    <= '0;
      timeout_event_q <= 1'b0;
      cause_nak_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      replay_req_q    <= replay_req_d;
      retrain_req_q   <= retrain_req_d;
      timer_hold_q    <= timer_hold_d;
      replay_num_q    <= replay_num_d;
      timeout_event_q <= timeout_event_d;
      cause_nak_q     <= cause_nak_d;
    end
  end

  assign replay_req       = replay_req_q;
  assign retrain_req      = retrain_req_q;
  assign timer_hold       = timer_hold_q;
  assign replay_num       = replay_num_q;
  assign timeout_event    = timeout_event_q;
  assign replay_cause_nak = cause_nak_q;

endmodule

// File: tb/tb_flit_replay_timeout_ctrl.sv
// Directed bench for flit_replay_timeout_ctrl; expected outputs are queued per cycle and checked
// by an independent monitor one time step after each rising edge.
module tb_flit_replay_timeout_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] cnt;
  logic [10:0] lim;
  logic        ack, nak, bne, rdone, tdone;
  logic        replay_req, retrain_req, timer_hold, timeout_event, replay_cause_nak;
  logic [1:0]  replay_num;

  typedef struct packed {
    logic       rr;
    logic       tr;
    logic       th;
    logic [1:0] num;
    logic       te;
    logic       cn;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  flit_replay_timeout_ctrl #(.CNT_W(11), .RNUM_W(2)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .replay_timeout_flit_count (cnt),
    .cfg_timeout_limit         (lim),
    .ack_progress              (ack),
    .nak                       (nak),
    .tx_retry_buffer_not_empty (bne),
    .replay_done               (rdone),
    .retrain_done              (tdone),
    .replay_req                (replay_req),
    .retrain_req               (retrain_req),
    .timer_hold                (timer_hold),
    .replay_num                (replay_num),
    .timeout_event             (timeout_event),
    .replay_cause_nak          (replay_cause_nak)
  );

  always #5 clk = ~clk;

  // Monitor: compares the outputs after every edge against the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = '{rr: replay_req, tr: retrain_req, th: timer_hold, num: replay_num,
              te: timeout_event, cn: replay_cause_nak};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got rr=%b tr=%b th=%b num=%0d te=%b cn=%b, expected rr=%b tr=%b th=%b num=%0d te=%b cn=%b",
                   n, a.rr, a.tr, a.th, a.num, a.te, a.cn, e.rr, e.tr, e.th, e.num, e.te, e.cn);
        end
      end
    end
  end

  // Queue the outputs expected after the next edge for the inputs now applied, advance one
  // cycle, then drop the single-cycle pulse inputs.
  task automatic cyc(input string nm, input bit rr, input bit tr, input bit th,
                     input logic [1:0] num, input bit te, input bit cn);
    exp_q.push_back('{rr: rr, tr: tr, th: th, num: num, te: te, cn: cn});
    name_q.push_back(nm);
    @(posedge clk);
    #2;
    ack   = 1'b0;
    nak   = 1'b0;
    rdone = 1'b0;
    tdone = 1'b0;
  endtask

  // Timeout-caused replay with limit 5, followed by replay completion.
  task automatic timeout_replay(input logic [1:0] n);
    cnt = 11'd5;
    cyc("to_replay", 1, 0, 1, n, 1, 0);
    cnt   = 11'd0;
    rdone = 1'b1;
    cyc("to_replay_done", 0, 0, 0, n, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cnt   = '0;
    lim   = '0;
    ack   = 1'b0;
    nak   = 1'b0;
    bne   = 1'b0;
    rdone = 1'b0;
    tdone = 1'b0;
    @(posedge clk);
    #2;
    cyc("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Basic timeout: limit 10, count ramps up to it.
    lim = 11'd10;
    bne = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cnt = 11'(c);
      cyc("ramp_below_limit", 0, 0, 0, 0, 0, 0);
    end
    cnt = 11'd10;
    cyc("basic_timeout", 1, 0, 1, 1, 1, 0);
    cnt = 11'd0;
    cyc("basic_hold", 1, 0, 1, 1, 0, 0);
    rdone = 1'b1;
    cyc("basic_replay_done", 0, 0, 0, 1, 0, 0);
    rdone = 1'b1;
    cyc("stray_replay_done_idle", 0, 0, 0, 1, 0, 0);
    ack = 1'b1;
    cyc("ack_clears_num", 0, 0, 0, 0, 0, 0);

    // Disabled limit and empty buffer.
    lim = 11'd0;
    cnt = 11'h7FF;
    cyc("limit_zero_disabled", 0, 0, 0, 0, 0, 0);
    lim = 11'd5;
    cnt = 11'd0;
    bne = 1'b0;
    nak = 1'b1;
    cyc("nak_buffer_empty", 0, 0, 0, 0, 0, 0);
    cnt = 11'h7FF;
    cyc("timeout_buffer_empty", 0, 0, 0, 0, 0, 0);
    cnt = 11'd0;
    bne = 1'b1;

    // Rollover to retrain.
    timeout_replay(2'd1);
    timeout_replay(2'd2);
    timeout_replay(2'd3);
    cnt = 11'd5;
    cyc("rollover_retrain", 0, 1, 1, 0, 1, 0);
    cnt = 11'd0;
    nak = 1'b1;
    ack = 1'b1;
    cyc("retrain_ignores_nak_ack", 0, 1, 1, 0, 0, 0);
    rdone = 1'b1;
    cnt   = 11'd6;
    cyc("retrain_ignores_replay_done", 0, 1, 1, 0, 0, 0);
    cnt   = 11'd0;
    tdone = 1'b1;
    cyc("retrain_done_replay", 1, 0, 1, 0, 0, 0);
    nak = 1'b1;
    cyc("replay_ignores_nak", 1, 0, 1, 0, 0, 0);
    rdone = 1'b1;
    cyc("post_retrain_replay_done", 0, 0, 0, 0, 0, 0);

    // Simultaneous events.
    timeout_replay(2'd1);
    nak = 1'b1;
    cnt = 11'd5;
    cyc("nak_and_timeout", 1, 0, 1, 2, 0, 1);
    cnt   = 11'd0;
    rdone = 1'b1;
    cyc("nak_and_timeout_done", 0, 0, 0, 2, 0, 1);
    ack = 1'b1;
    cnt = 11'd5;
    cyc("ack_and_timeout", 0, 0, 0, 0, 0, 1);
    cnt = 11'd0;
    timeout_replay(2'd1);
    timeout_replay(2'd2);
    timeout_replay(2'd3);
    ack = 1'b1;
    nak = 1'b1;
    cyc("ack_and_nak_at_3", 1, 0, 1, 1, 0, 1);
    ack = 1'b1;
    cyc("replay_ack_clears", 1, 0, 1, 0, 0, 1);
    rdone = 1'b1;
    cyc("replay_done_after_ack", 0, 0, 0, 0, 0, 1);

    // Reset while in RETRAIN, then a fresh saturated-count timeout.
    timeout_replay(2'd1);
    timeout_replay(2'd2);
    timeout_replay(2'd3);
    cnt = 11'd5;
    cyc("retrain_before_reset", 0, 1, 1, 0, 1, 0);
    cnt   = 11'd0;
    nak   = 1'b1;
    rst_n = 1'b0;
    cyc("reset_mid_retrain", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("idle_after_reset", 0, 0, 0, 0, 0, 0);
    cnt = 11'h7FF;
    cyc("fresh_timeout", 1, 0, 1, 1, 1, 0);
    cnt = 11'd0;
    cyc("fresh_hold", 1, 0, 1, 1, 0, 0);
    rdone = 1'b1;
    cyc("fresh_replay_done", 0, 0, 0, 1, 0, 0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
